// File: rtl/dct_transpose_scheduler_if.sv
// Stream bundle between the row-pass DCT, the transpose scheduler and the column-pass DCT.
// The master drives row samples and the downstream stall; the slave returns column samples and status.
interface dct_transpose_scheduler_if #(
  parameter int WIDTH = 10
);
  logic                    sample_en;
  logic signed [WIDTH-1:0] sample;
  logic                    hold;
  logic                    ready;
  logic                    col_en;
  logic signed [WIDTH-1:0] col_data;
  logic                    block_done;
  logic                    overflow;

  modport master (
    output sample_en, sample, hold,
    input  ready, col_en, col_data, block_done, overflow
  );

  modport slave (
    input  sample_en, sample, hold,
    output ready, col_en, col_data, block_done, overflow
  );
endinterface

// File: rtl/dct_transpose_scheduler.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes.
// Blocks are written row-major into one bank while the other bank is replayed column-major.
module dct_transpose_scheduler #(
  parameter int WIDTH = 10
) (
  input logic                   clk,
  input logic                   rst,
  dct_transpose_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  rd_state_t state, state_next;

  logic signed [WIDTH-1:0] mem [2][64];

  logic       wr_bank;
  logic       rd_bank;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic [1:0] full;

  logic       wr_accept;
  logic       wr_last;
  logic       rd_issue;
  logic       rd_last;
  logic       other_full;
  logic [5:0] rd_index;

  logic                    col_en_q;
  logic signed [WIDTH-1:0] col_data_q;
  logic                    block_done_q;
  logic                    overflow_q;

  assign wr_accept  = bus.sample_en && !full[wr_bank];
  assign wr_last    = wr_accept && (wr_cnt == 6'd63);
  assign rd_last    = rd_issue && (rd_cnt == 6'd63);
  assign other_full = full[~rd_bank];
  // Column-major replay: rd_cnt low bits pick the row, high bits the column.
  assign rd_index   = {rd_cnt[2:0], rd_cnt[5:3]};

  assign bus.ready      = !full[wr_bank];
  assign bus.col_en     = col_en_q;
  assign bus.col_data   = col_data_q;
  assign bus.block_done = block_done_q;
  assign bus.overflow   = overflow_q;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank] && !bus.hold) begin
          rd_issue   = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (!bus.hold) begin
          rd_issue = 1'b1;
          if (rd_cnt == 6'd63) begin
            state_next = other_full ? READ : IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: the sample array is deliberately left out of reset; its contents are only
  // observable after a bank has been completely rewritten and marked full.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_bank][wr_cnt] <= bus.sample;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_cnt       <= 6'd0;
      rd_cnt       <= 6'd0;
      full         <= 2'b00;
      overflow_q   <= 1'b0;
      col_en_q     <= 1'b0;
      col_data_q   <= '0;
      block_done_q <= 1'b0;
    end else begin
      state <= state_next;

      if (wr_accept) begin
        wr_cnt <= wr_cnt + 6'd1;
      end
      if (wr_last) begin
        wr_bank       <= ~wr_bank;
        full[wr_bank] <= 1'b1;
      end
      if (bus.sample_en && full[wr_bank]) begin
        overflow_q <= 1'b1;
      end

      if (rd_issue) begin
        rd_cnt     <= rd_cnt + 6'd1;
        col_data_q <= mem[rd_bank][rd_index];
      end
      // Release and fill always target different banks, so both updates land.
      if (rd_last) begin
        rd_bank       <= ~rd_bank;
        full[rd_bank] <= 1'b0;
      end

      col_en_q     <= rd_issue;
      block_done_q <= rd_last;
    end
  end

endmodule

// File: tb/tb_dct_transpose_scheduler.sv
// Scoreboard bench for dct_transpose_scheduler: each completed input block pushes its
// transposed sequence; the output monitor pops and compares data and block_done.
module tb_dct_transpose_scheduler;

  localparam int WIDTH = 10;

  typedef struct {
    logic signed [WIDTH-1:0] data;
    logic                    last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dct_transpose_scheduler_if #(.WIDTH(WIDTH)) bus ();

  dct_transpose_scheduler #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t                    sb[$];
  exp_t                    mon_e;
  logic signed [WIDTH-1:0] blk[64];
  int                      blk_n = 0;
  int                      last_in_cyc = 0;
  int                      out_count = 0;
  int                      first_out_cyc = 0;
  int                      last_out_cyc = 0;
  logic signed [WIDTH-1:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Output monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.col_en) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("col_data", 32'(bus.col_data), 32'(mon_e.data));
          check("block_done", 32'(bus.block_done), 32'(mon_e.last));
        end
        if (out_count == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_count++;
        last_data = bus.col_data;
      end else begin
        check("idle_outputs", 32'({bus.block_done, bus.col_data}), 32'({1'b0, last_data}));
      end
    end
  end

  // Drives one sample for one cycle; called on a falling edge.
  task automatic send(input logic signed [WIDTH-1:0] v, input bit drop);
    bus.sample    = v;
    bus.sample_en = 1'b1;
    check("in_ready", 32'(bus.ready), 32'(!drop));
    if (!drop) begin
      last_in_cyc = cyc;
      blk[blk_n]  = v;
      blk_n++;
      if (blk_n == 64) begin
        for (int i = 0; i < 64; i++) begin
          exp_t e;
          e.data = blk[(i % 8) * 8 + i / 8];
          e.last = (i == 63);
          sb.push_back(e);
        end
        blk_n = 0;
      end
    end
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.sample_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.hold      = 1'b0;
    repeat (2) @(negedge clk);
    blk_n     = 0;
    sb.delete();
    last_data = '0;
    rst       = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_en"}, 32'(bus.col_en), 32'd0);
    check({tag, "_col_data"}, 32'(bus.col_data), 32'd0);
    check({tag, "_block_done"}, 32'(bus.block_done), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c0;
    bus.sample_en = 1'b0;
    bus.sample    = '0;
    bus.hold      = 1'b0;
    @(negedge clk);
    do_reset();
    check_reset_values("reset");

    // Single block on consecutive cycles: outputs at +65..+128.
    out_count = 0;
    c0 = cyc;
    for (int k = 0; k < 64; k++) send(WIDTH'(k), 1'b0);
    drain("single");
    check("single_count", 32'(out_count), 32'd64);
    check("single_first", 32'(first_out_cyc - c0), 32'd65);
    check("single_last", 32'(last_out_cyc - c0), 32'd128);

    // Same block with a gap after every sample: first output 2 cycles after the 64th.
    out_count = 0;
    for (int k = 0; k < 64; k++) begin
      send(WIDTH'(k), 1'b0);
      idle(1);
    end
    drain("sparse");
    check("sparse_count", 32'(out_count), 32'd64);
    check("sparse_latency", 32'(first_out_cyc - last_in_cyc), 32'd2);

    // Three back-to-back blocks; block 0 release and block 1 fill coincide.
    out_count = 0;
    c0 = cyc;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 64; k++) send(WIDTH'(k + 64 * b), 1'b0);
    drain("stream");
    check("stream_count", 32'(out_count), 32'd192);
    check("stream_first", 32'(first_out_cyc - c0), 32'd65);
    check("stream_gapless", 32'(last_out_cyc - first_out_cyc), 32'd191);
    check("stream_overflow", 32'(bus.overflow), 32'd0);

    // Hold from output index 10 for 150 cycles while 129 samples arrive.
    out_count = 0;
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 129; i++) send(WIDTH'(i), i == 128);
      end
      begin
        repeat (74) @(negedge clk);
        bus.hold = 1'b1;
        repeat (150) @(negedge clk);
        check("hold_frozen", 32'(out_count), 32'd10);
        bus.hold = 1'b0;
      end
    join
    drain("hold");
    check("hold_count", 32'(out_count), 32'd128);
    check("hold_overflow", 32'(bus.overflow), 32'd1);
    check("hold_ready_after", 32'(bus.ready), 32'd1);

    // Reset in the middle of a block discards it; the next block is clean.
    for (int k = 0; k < 30; k++) send(WIDTH'(-(3 * k + 1)), 1'b0);
    do_reset();
    check_reset_values("midreset");
    out_count = 0;
    for (int k = 0; k < 64; k++) send(WIDTH'(5 * k - 100), 1'b0);
    drain("after_reset");
    check("after_reset_count", 32'(out_count), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
